clkdiv_prog: RTL and testbench
==============================

# clkdiv_prog

Multi-channel programmable clock-enable generator, the parametrised successor to the fixed power-of-two divider. It derives CH independent periodic outputs from mclk, each with a runtime-programmable integer divisor rather than a fixed counter tap. Each channel produces a one-cycle enable pulse (tick) and an optional near-50% square wave (clk_out). It feeds display scanning, debouncers and slow FSMs in the lab designs; all consumers use tick as a clock enable on mclk.

## Interface
- CH, 4: number of channels (1..16).
- DIVW, 28: divisor and counter width in bits.
- DEF_DIV, 100_000_000: reset divisor for every channel; must fit in DIVW bits.

- mclk  in  1  system clock; all logic on the rising edge.
- clr_n  in  1  reset; asynchronous assert, active-low.
- sync  in  1  synchronous restart of all channel counters.
- cfg_valid  in  1  divisor update request.
- cfg_ready  out  1  update slot free.
- cfg_ch  in  $clog2(CH) (min 1)  target channel.
- cfg_div  in  DIVW  new divisor; 0 disables the channel.
- tick  out  CH  one-cycle enable per channel.
- clk_out  out  CH  square output per channel.

## Operation
- Per channel: registers cnt and div.
  - On clr_n low: cnt=0, div=DEF_DIV, tick=0, clk_out=0.
  - Reset-driven cfg_ready=1; no update pending.
- Counting with div≥1, at each edge:
  - If cnt==div-1: cnt←0 and tick←1.
  - Otherwise: cnt←cnt+1 and tick←0.
- Square output: clk_out←(cnt_next ≥ div>>1).
  - This gives floor(div/2) cycles low, then ceil(div/2) cycles high, per period.
  - div=1: tick and clk_out are both constantly 1 after the first edge.
- Disabled channel (div==0): cnt held 0; tick=0; clk_out=0.
- Config handshake:
  - A transfer occurs on an edge where cfg_valid && cfg_ready.
  - It loads a single pending slot (channel, divisor) and drops cfg_ready.
  - A cfg_ch ≥ CH is accepted and discarded; cfg_ready stays 1.
- Applying a pending update:
  - It applies at the target channel's terminal edge (the cnt==div-1 edge): div←new, cnt←0.
  - If the target is disabled, it applies on the next edge.
  - cfg_ready returns to 1 on the edge that applies it.
  - Updates never truncate or stretch a running period, so there are no glitches.
- Sync:
  - sync=1 forces every cnt←0, tick←0, clk_out←0 on that edge.
  - Any pending update is applied on the same edge.
- Simultaneous events:
  - sync has priority over the terminal count.
  - If a transfer coincides with an apply, the new request is not accepted, because cfg_ready was 0.
- Reset mid-operation: the pending update is lost; all channels return to DEF_DIV.

## Timing
- After clr_n deasserts, the first tick is high for the cycle after edge number div. The period is then exactly div cycles.
- Latency of a divisor update:
  - Accept edge to apply edge: between 1 and old div cycles.
  - First tick at the new rate: new div cycles after the apply edge.
- After sync, the first tick follows sync's edge by div cycles. All channels with equal div are phase-aligned.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- CLKDIV_SQUARE_EN defined: clk_out logic is built as described.
- Not defined:
  - clk_out is tied to 0 and its comparators are removed.
  - tick behaviour and timing are unchanged.

## Structure
- Package clkdiv_pkg holds:
  - DIVW_DEFAULT;
  - a cfg_req_t struct (ch, div);
  - the function div_half(d)=d>>1.
- One sub-module, clkdiv_chan, is instantiated CH times via generate. It holds cnt, div, tick, clk_out and an apply input.
- The top level holds the pending slot, the handshake and the sync fan-out.

## Test plan
- Reset release, CH=2, DEF_DIV=4 → tick[0] high on cycles 4, 8, 12; clk_out pattern 0,0,1,1 repeating.
- Program ch1 cfg_div=5 mid-period (cnt=1) → cfg_ready low for 3 cycles. Old period completes, then ticks every 5 cycles; clk_out low 2, high 3.
- Program cfg_div=0 on ch0 → applies at ch0's terminal edge; tick[0]/clk_out[0] stay 0. Reprogram to 3 → applies next edge, period 3.
- sync pulse while ch0 (div 4) is at cnt=2 and an update to 6 is pending → both counters restart. The next tick comes 6 cycles after sync; cfg_ready=1 the following cycle.
- cfg_ch=CH (out of range) with cfg_valid → accepted, cfg_ready stays 1, no channel changes.
- Async clr_n pulse mid-period with an update pending → outputs 0 immediately, pending dropped, DEF_DIV restored. Rebuild without CLKDIV_SQUARE_EN → clk_out constant 0.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared types, widths and helpers for the programmable clock-enable generator
package clkdiv_pkg;

    localparam int DIVW_DEFAULT = 28;
    localparam int CH_W_MAX     = 4;
    localparam int DIV_W_MAX    = 32;

    // One pending divisor update; fields sized for the largest legal configuration.
    typedef struct packed {
        logic [CH_W_MAX-1:0]  ch;
        logic [DIV_W_MAX-1:0] div;
    } cfg_req_t;

    // Low-phase length of the square output: floor(d/2) cycles.
    function automatic logic [DIV_W_MAX-1:0] div_half(input logic [DIV_W_MAX-1:0] d);
        return d >> 1;
    endfunction

endpackage

// File: rtl/clkdiv_if.sv
// rtl/clkdiv_if.sv - divisor update request channel with master/slave views
interface clkdiv_if
    import clkdiv_pkg::*;
#(
    parameter int CH   = 4,
    parameter int DIVW = DIVW_DEFAULT
);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    logic            cfg_valid;
    logic            cfg_ready;
    logic [CHW-1:0]  cfg_ch;
    logic [DIVW-1:0] cfg_div;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ready
    );

endinterface

// File: rtl/clkdiv_chan.sv
// rtl/clkdiv_chan.sv - one divider channel; square output built only when CLKDIV_SQUARE_EN is defined
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int              DIVW    = DIVW_DEFAULT,
    parameter logic [DIVW-1:0] DEF_DIV = DIVW'(100)
) (
    input  logic            mclk,
    input  logic            clr_n,
    input  logic            sync,
    input  logic            apply,
    input  logic [DIVW-1:0] new_div,
    output logic            apply_ok,
    output logic            tick,
    output logic            clk_out
);

    logic [DIVW-1:0] cnt_q, cnt_d;
    logic [DIVW-1:0] div_q, div_d;
    logic            tick_q, tick_d;
    logic            last;

    // Terminal edge closes the current period; a new divisor may only land here,
    // on a restart, or while the channel is idle, so periods are never cut short.
    assign last     = (div_q != '0) && (cnt_q == div_q - 1'b1);
    assign apply_ok = sync || (div_q == '0) || last;

    // Counter, divisor and tick next-state.
    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        tick_d = 1'b0;
        if (sync) begin
            cnt_d = '0;
        end else if (div_q == '0) begin
            cnt_d = '0;
        end else if (last) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        if (apply && apply_ok) begin
            div_d = new_div;
        end
    end

    // Counter, divisor and tick registers.
    always_ff @(posedge mclk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q  <= '0;
            div_q  <= DEF_DIV;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

`ifdef CLKDIV_SQUARE_EN
    logic clk_q, clk_d;

    // High once the post-edge count reaches half the post-edge divisor; idle channels stay low.
    always_comb begin
        clk_d = !sync && (div_d != '0) &&
                (cnt_d >= DIVW'(div_half(DIV_W_MAX'(div_d))));
    end

    // Square output register.
    always_ff @(posedge mclk or negedge clr_n) begin
        if (!clr_n) begin
            clk_q <= 1'b0;
        end else begin
            clk_q <= clk_d;
        end
    end

    assign clk_out = clk_q;
`else
    assign clk_out = 1'b0;
`endif

endmodule

// File: rtl/clkdiv_prog.sv
// rtl/clkdiv_prog.sv - multi-channel programmable clock-enable generator top (CLKDIV_SQUARE_EN builds clk_out)
module clkdiv_prog
    import clkdiv_pkg::*;
#(
    parameter int          CH      = 4,
    parameter int          DIVW    = DIVW_DEFAULT,
    parameter int unsigned DEF_DIV = 100_000_000
) (
    input  logic          mclk,
    input  logic          clr_n,
    input  logic          sync,
    clkdiv_if.slave       cfg,
    output logic [CH-1:0] tick,
    output logic [CH-1:0] clk_out
);

    cfg_req_t      pend_q, pend_d;
    logic          ready_q, ready_d;
    logic          in_range;
    logic [CH-1:0] apply;
    logic [CH-1:0] apply_ok;

    assign in_range      = int'(cfg.cfg_ch) < CH;
    assign cfg.cfg_ready = ready_q;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        // The slot is full whenever ready is low; only its target channel sees apply.
        assign apply[i] = !ready_q && (pend_q.ch == CH_W_MAX'(i)) && apply_ok[i];

        clkdiv_chan #(
            .DIVW    (DIVW),
            .DEF_DIV (DIVW'(DEF_DIV))
        ) u_chan (
            .mclk     (mclk),
            .clr_n    (clr_n),
            .sync     (sync),
            .apply    (apply[i]),
            .new_div  (DIVW'(pend_q.div)),
            .apply_ok (apply_ok[i]),
            .tick     (tick[i]),
            .clk_out  (clk_out[i])
        );
    end

    // Pending slot: fill on a handshake, free on the edge the target channel takes it.
    // Out-of-range channels complete the handshake but are dropped.
    always_comb begin
        pend_d  = pend_q;
        ready_d = ready_q;
        if (!ready_q) begin
            if (|apply) begin
                ready_d = 1'b1;
            end
        end else if (cfg.cfg_valid && in_range) begin
            pend_d.ch  = CH_W_MAX'(cfg.cfg_ch);
            pend_d.div = DIV_W_MAX'(cfg.cfg_div);
            ready_d    = 1'b0;
        end
    end

    // Pending slot and ready registers.
    always_ff @(posedge mclk or negedge clr_n) begin
        if (!clr_n) begin
            pend_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            pend_q  <= pend_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: tb/tb_clkdiv_prog.sv
// tb/tb_clkdiv_prog.sv - self-checking bench for clkdiv_prog (expects clk_out activity only with CLKDIV_SQUARE_EN)
module tb_clkdiv_prog;

    localparam int CH      = 3;
    localparam int DIVW    = 8;
    localparam int DEF_DIV = 4;
`ifdef CLKDIV_SQUARE_EN
    localparam bit SQ = 1'b1;
`else
    localparam bit SQ = 1'b0;
`endif

    logic          mclk  = 1'b0;
    logic          clr_n = 1'b0;
    logic          sync  = 1'b0;
    logic [CH-1:0] tick;
    logic [CH-1:0] clk_out;

    clkdiv_if #(.CH(CH), .DIVW(DIVW)) cfg ();

    clkdiv_prog #(
        .CH      (CH),
        .DIVW    (DIVW),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .mclk    (mclk),
        .clr_n   (clr_n),
        .sync    (sync),
        .cfg     (cfg),
        .tick    (tick),
        .clk_out (clk_out)
    );

    always #5 mclk = ~mclk;

    int checks = 0;
    int errors = 0;

    // Reference model: each channel is described by the edge its current period
    // started on and its divisor; outputs follow from modulo arithmetic on the edge number.
    int n;
    int m_s [CH];
    int m_d [CH];
    bit m_tick [CH];
    bit m_clk [CH];
    bit m_pend;
    int m_pch;
    int m_pdiv;

    typedef struct {
        bit         s;
        bit         v;
        int         ch;
        int         dv;
        logic [2:0] et;
        logic [2:0] ec;
        bit         er;
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit sq_of(input int i);
        if (!SQ || m_d[i] == 0) return 1'b0;
        return ((n - m_s[i]) % m_d[i]) >= (m_d[i] / 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_s[i]    = n;
            m_d[i]    = DEF_DIV;
            m_tick[i] = 1'b0;
            m_clk[i]  = 1'b0;
        end
        m_pend = 1'b0;
    endtask

    task automatic model_edge(input bit s, input bit v, input int ch, input int dv);
        bit hit = 1'b0;
        n++;
        for (int i = 0; i < CH; i++) begin
            bit tgt = m_pend && (m_pch == i);
            if (s) begin
                m_s[i]    = n;
                m_tick[i] = 1'b0;
                if (tgt) begin m_d[i] = m_pdiv; hit = 1'b1; end
                m_clk[i]  = 1'b0;
            end else if (m_d[i] == 0) begin
                m_tick[i] = 1'b0;
                if (tgt) begin m_d[i] = m_pdiv; m_s[i] = n; hit = 1'b1; end
                m_clk[i]  = sq_of(i);
            end else begin
                m_tick[i] = ((n - m_s[i]) % m_d[i]) == 0;
                if (m_tick[i] && tgt) begin m_d[i] = m_pdiv; m_s[i] = n; hit = 1'b1; end
                m_clk[i]  = sq_of(i);
            end
        end
        if (m_pend) begin
            if (hit) m_pend = 1'b0;
        end else if (v && ch < CH) begin
            m_pend = 1'b1;
            m_pch  = ch;
            m_pdiv = dv;
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("tick[%0d]", i), 32'(tick[i]), 32'(m_tick[i]));
            chk($sformatf("clk_out[%0d]", i), 32'(clk_out[i]), 32'(m_clk[i]));
        end
        chk("cfg_ready", 32'(cfg.cfg_ready), 32'(!m_pend));
    endtask

    task automatic step(input bit s, input bit v, input int ch, input int dv);
        sync          = s;
        cfg.cfg_valid = v;
        cfg.cfg_ch    = ch[1:0];
        cfg.cfg_div   = dv[DIVW-1:0];
        @(posedge mclk);
        model_edge(s, v, ch, dv);
        #1;
        compare_all();
        sync          = 1'b0;
        cfg.cfg_valid = 1'b0;
    endtask

    task automatic run_idle(input int k, input int c, output int first, output int gap, output int cnt);
        int prev = -1;
        first = -1;
        gap   = -1;
        cnt   = 0;
        for (int j = 0; j < k; j++) begin
            step(1'b0, 1'b0, 0, 0);
            if (tick[c]) begin
                if (cnt == 0) first = n;
                else if (cnt == 1) gap = n - prev;
                prev = n;
                cnt++;
            end
        end
    endtask

    task automatic do_reset();
        #2;
        clr_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        #2;
        clr_n = 1'b1;
    endtask

    initial begin
        int first, gap, cnt, base;

        tbl[0]  = '{0, 0, 0, 0, 3'b000, 3'b000, 1};
        tbl[1]  = '{0, 0, 0, 0, 3'b000, 3'b111, 1};
        tbl[2]  = '{0, 0, 0, 0, 3'b000, 3'b111, 1};
        tbl[3]  = '{0, 0, 0, 0, 3'b111, 3'b000, 1};
        tbl[4]  = '{0, 0, 0, 0, 3'b000, 3'b000, 1};
        tbl[5]  = '{0, 0, 0, 0, 3'b000, 3'b111, 1};
        tbl[6]  = '{0, 0, 0, 0, 3'b000, 3'b111, 1};
        tbl[7]  = '{0, 0, 0, 0, 3'b111, 3'b000, 1};
        tbl[8]  = '{0, 0, 0, 0, 3'b000, 3'b000, 1};
        tbl[9]  = '{0, 0, 0, 0, 3'b000, 3'b111, 1};
        tbl[10] = '{0, 0, 0, 0, 3'b000, 3'b111, 1};
        tbl[11] = '{0, 0, 0, 0, 3'b111, 3'b000, 1};
        tbl[12] = '{0, 1, 1, 5, 3'b000, 3'b000, 0};
        tbl[13] = '{0, 0, 0, 0, 3'b000, 3'b111, 0};
        tbl[14] = '{0, 0, 0, 0, 3'b000, 3'b111, 0};
        tbl[15] = '{0, 0, 0, 0, 3'b111, 3'b000, 1};

        cfg.cfg_valid = 1'b0;
        cfg.cfg_ch    = '0;
        cfg.cfg_div   = '0;
        n             = 0;

        repeat (2) @(posedge mclk);
        #3;
        model_reset();
        chk("reset_tick", 32'(tick), 32'(0));
        chk("reset_clk", 32'(clk_out), 32'(0));
        chk("reset_ready", 32'(cfg.cfg_ready), 32'(1));
        clr_n = 1'b1;

        for (int k = 0; k < 16; k++) begin
            step(tbl[k].s, tbl[k].v, tbl[k].ch, tbl[k].dv);
            chk($sformatf("tbl%0d_tick", k), 32'(tick), 32'(tbl[k].et));
            chk($sformatf("tbl%0d_clk", k), 32'(clk_out), SQ ? 32'(tbl[k].ec) : 32'(0));
            chk($sformatf("tbl%0d_ready", k), 32'(cfg.cfg_ready), 32'(tbl[k].er));
        end

        run_idle(10, 1, first, gap, cnt);
        chk("div5_first", first, 21);
        chk("div5_gap", gap, 5);
        chk("div5_count", cnt, 2);

        step(1'b0, 1'b1, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        chk("disable_last_tick", 32'(tick[0]), 32'(1));
        run_idle(8, 0, first, gap, cnt);
        chk("disabled_no_tick", cnt, 0);
        step(1'b0, 1'b1, 0, 3);
        chk("reenable_ready_low", 32'(cfg.cfg_ready), 32'(0));
        run_idle(7, 0, first, gap, cnt);
        chk("div3_first", first, 41);
        chk("div3_gap", gap, 3);

        do_reset();
        base = n;
        step(1'b0, 1'b1, 0, 6);
        step(1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        chk("sync_ready", 32'(cfg.cfg_ready), 32'(1));
        run_idle(8, 0, first, gap, cnt);
        chk("sync_first_tick", first - base, 9);

        step(1'b0, 1'b1, 3, 7);
        chk("oor_ready", 32'(cfg.cfg_ready), 32'(1));

        step(1'b0, 1'b1, 2, 9);
        step(1'b0, 1'b0, 0, 0);
        do_reset();
        chk("rst_ready", 32'(cfg.cfg_ready), 32'(1));
        chk("rst_tick", 32'(tick), 32'(0));
        base = n;
        run_idle(4, 2, first, gap, cnt);
        chk("rst_def_tick", first - base, 4);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            step($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 9)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
